data_cache: RTL and testbench
=============================

Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache.
- Sits between the load/store unit and the memory bus.
- Serves demand word reads and a one-entry prefetch hint from the load/store unit, and committed stores from the ROB.
- Refills whole lines from memory one word per handshake.

Parameters:
LINE_NUM, 16, number of cache lines (power of two)
WORDS_PER_LINE, 4, 32-bit words per line (power of two)
ADDR_WIDTH, 32, byte-address width
DATA_WIDTH, 32, word width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
dcache_read  in  1  demand read request, level, held until done
dcache_read_addr  in  ADDR_WIDTH  word-aligned read address
dcache_read_done  out  1  read data valid this cycle
dcache_read_data  out  DATA_WIDTH  read word
dcache_prefetch  in  1  prefetch hint valid
dcache_pre_addr  in  ADDR_WIDTH  prefetch byte address
dcache_write  in  1  committed store request, level, held until done
dcache_write_addr  in  ADDR_WIDTH  store address, word-aligned
dcache_write_data  in  DATA_WIDTH  store data, already lane-aligned
dcache_write_mask  in  4  byte enables
dcache_write_done  out  1  store accepted by memory
mem_req  out  1  memory request valid
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_WIDTH  word address
mem_wdata  out  DATA_WIDTH  write data
mem_wmask  out  4  byte enables
mem_ack  in  1  request completed; mem_rdata valid for reads
mem_rdata  in  DATA_WIDTH  read data

Behaviour:
- Address split: offset[1:0], word = next log2(WORDS_PER_LINE) bits, index = next log2(LINE_NUM) bits, tag = remainder.
- Per-line state: valid bit, tag, WORDS_PER_LINE data words.

Reset (rst low, asynchronous):
- All valid bits 0; FSM to IDLE; prefetch slot empty.
- Outputs: mem_req, mem_we, dcache_read_done, dcache_write_done = 0; mem_addr, mem_wdata, mem_wmask, dcache_read_data = 0.
- Reset mid-refill abandons the refill; the line stays invalid.

FSM states:
- IDLE:
  - Hit = dcache_read && valid[index] && tag match, with no refill in progress. On a hit, dcache_read_done = 1 combinationally in the same cycle and dcache_read_data = the stored word (zero-latency hit).
  - Priority among new actions: dcache_write, then demand read miss, then pending prefetch miss.
  - Write → WRITE. Read miss → REFILL with fill base = line address of dcache_read_addr. Prefetch miss → REFILL with fill base = prefetch line.
- REFILL:
  - mem_req = 1, mem_we = 0, mem_addr = fill base + 4*fill_cnt.
  - On each mem_ack: store mem_rdata into word fill_cnt, then fill_cnt increments.
  - On the ack with fill_cnt == WORDS_PER_LINE-1: set valid, write tag, go to IDLE. A pending demand read hits on the next cycle.
  - fill_cnt wraps to 0 after the last word.
- WRITE:
  - mem_req = 1, mem_we = 1; address, data and mask taken from the dcache_write inputs.
  - On mem_ack: dcache_write_done = 1 for that cycle. If the line hits, merge the masked bytes into the cached word in the same cycle. Go to IDLE.
  - On a miss, no allocation.

Prefetch slot (one entry):
- Whenever dcache_prefetch = 1, the slot captures dcache_pre_addr; a newer hint overwrites an older one.
- The slot is cleared when its refill starts, or when it is found to hit in IDLE.
- A hint arriving in the cycle its refill starts is captured (the new hint wins).
- Refills are non-blocking to nothing: a demand read during any refill waits until IDLE, including a read to the line being filled.
- mem_req stays high until mem_ack; request fields are stable while mem_req is high.
- dcache_read_done and dcache_write_done are never asserted in the same cycle as reset.

Decomposition:
- Shared defines header holds: Addr_Width, Data_Width, FSM state encodings (IDLE/REFILL/WRITE), index/tag/offset interval macros.
- One natural sub-module: data_cache_array (valid/tag/data storage).
  - Async read port for hit lookup.
  - Synchronous word write port with byte mask, used by both refill and store merge.
  - Asynchronous reset of valid bits.

Test Plan:
- Reset then dcache_read addr 0x100; memory returns 0xA0..0xA3 with ack every 2 cycles → four mem reads at 0x100,0x104,0x108,0x10C, then dcache_read_done with data 0xA0 one cycle after the last ack.
- Read 0x108 after the fill → done same cycle, data 0xA2, mem_req stays 0.
- Store 0x104 mask 4'b0011 data 0x0000BEEF over cached 0xA1A1A1A1 → mem write 0x104 mask 0011; done on ack; later read 0x104 returns 0xA1A1BEEF. Store to uncached 0x900 → memory write only, no refill.
- Prefetch 0x200 while idle → refill of 0x200 line; read 0x204 afterwards hits. Prefetch 0x300 then 0x400 during busy refill → only 0x400 is fetched.
- Simultaneous write and read miss in IDLE → write completes first, then refill.
- rst low during the 3rd refill word → mem_req 0 immediately, line invalid; a re-read misses and refetches all four words.

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared sizing defaults and FSM encoding for the L1 data cache.
package data_cache_pkg;

  localparam int DC_LINE_NUM       = 16;
  localparam int DC_WORDS_PER_LINE = 4;
  localparam int DC_ADDR_WIDTH     = 32;
  localparam int DC_DATA_WIDTH     = 32;
  localparam int DC_OFF_W          = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } dc_state_t;

endpackage

// File: rtl/data_cache_array.sv
// Valid/tag/data storage: async lookup ports, one synchronous byte-masked word write port.
// Lookups are combinational; writes land on the next rising edge, no backpressure.
module data_cache_array
  import data_cache_pkg::*;
#(
  parameter int  LINE_NUM       = DC_LINE_NUM,
  parameter int  WORDS_PER_LINE = DC_WORDS_PER_LINE,
  parameter int  DATA_WIDTH     = DC_DATA_WIDTH,
  parameter int  TAG_W          = 26,
  localparam int IDX_W          = $clog2(LINE_NUM),
  localparam int WORD_W         = $clog2(WORDS_PER_LINE),
  localparam int BE_W           = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      a_idx,
  input  logic [WORD_W-1:0]     a_word,
  output logic                  a_valid,
  output logic [TAG_W-1:0]      a_tag,
  output logic [DATA_WIDTH-1:0] a_data,
  input  logic [IDX_W-1:0]      b_idx,
  output logic                  b_valid,
  output logic [TAG_W-1:0]      b_tag,
  input  logic                  we,
  input  logic [IDX_W-1:0]      w_idx,
  input  logic [WORD_W-1:0]     w_word,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [BE_W-1:0]       w_mask,
  input  logic                  w_set_valid,
  input  logic [TAG_W-1:0]      w_tag
);

  logic [LINE_NUM-1:0]   valid_q;
  logic [TAG_W-1:0]      tag_q  [LINE_NUM];
  logic [DATA_WIDTH-1:0] data_q [LINE_NUM*WORDS_PER_LINE];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (we && w_set_valid) begin
      valid_q[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we && w_set_valid) begin
      tag_q[w_idx] <= w_tag;
    end
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (w_mask[i]) begin
          data_q[{w_idx, w_word}][8*i +: 8] <= w_data[8*i +: 8];
        end
      end
    end
  end

  assign a_valid = valid_q[a_idx];
  assign a_tag   = tag_q[a_idx];
  assign a_data  = data_q[{a_idx, a_word}];
  assign b_valid = valid_q[b_idx];
  assign b_tag   = tag_q[b_idx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through no-write-allocate L1 D-cache; hits return in the request cycle.
// Misses/stores hold the level request until done; memory port holds mem_req and fields until mem_ack.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int LINE_NUM       = DC_LINE_NUM,
  parameter int WORDS_PER_LINE = DC_WORDS_PER_LINE,
  parameter int ADDR_WIDTH     = DC_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DC_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dcache_read,
  input  logic [ADDR_WIDTH-1:0]   dcache_read_addr,
  output logic                    dcache_read_done,
  output logic [DATA_WIDTH-1:0]   dcache_read_data,
  input  logic                    dcache_prefetch,
  input  logic [ADDR_WIDTH-1:0]   dcache_pre_addr,
  input  logic                    dcache_write,
  input  logic [ADDR_WIDTH-1:0]   dcache_write_addr,
  input  logic [DATA_WIDTH-1:0]   dcache_write_data,
  input  logic [DATA_WIDTH/8-1:0] dcache_write_mask,
  output logic                    dcache_write_done,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int WORD_W   = $clog2(WORDS_PER_LINE);
  localparam int IDX_W    = $clog2(LINE_NUM);
  localparam int LINE_LSB = DC_OFF_W + WORD_W;
  localparam int TAG_LSB  = LINE_LSB + IDX_W;
  localparam int TAG_W    = ADDR_WIDTH - TAG_LSB;
  localparam int BE_W     = DATA_WIDTH / 8;

  dc_state_t                      state, state_nxt;
  logic [ADDR_WIDTH-1:LINE_LSB]   fill_line, fill_line_nxt, pf_line;
  logic [WORD_W-1:0]              fill_cnt;
  logic                           pf_vld, pf_clr;

  logic                  a_valid, b_valid, rd_hit, b_hit;
  logic [TAG_W-1:0]      a_tag, b_tag, b_cmp_tag;
  logic [DATA_WIDTH-1:0] a_data;
  logic [IDX_W-1:0]      b_idx;

  logic                  arr_we, arr_set_valid;
  logic [IDX_W-1:0]      arr_idx;
  logic [WORD_W-1:0]     arr_word;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [BE_W-1:0]       arr_wmask;
  logic [TAG_W-1:0]      arr_tag;

  logic unused;
  assign unused = ^{dcache_read_addr[DC_OFF_W-1:0], dcache_write_addr[DC_OFF_W-1:0],
                    dcache_pre_addr[LINE_LSB-1:0]};

  // Port b serves the store-hit check in WRITE and the prefetch-slot check otherwise.
  assign b_idx     = (state == WRITE) ? dcache_write_addr[TAG_LSB-1:LINE_LSB] : pf_line[TAG_LSB-1:LINE_LSB];
  assign b_cmp_tag = (state == WRITE) ? dcache_write_addr[ADDR_WIDTH-1:TAG_LSB] : pf_line[ADDR_WIDTH-1:TAG_LSB];
  assign b_hit     = b_valid && (b_tag == b_cmp_tag);

  assign rd_hit = (state == IDLE) && dcache_read && a_valid &&
                  (a_tag == dcache_read_addr[ADDR_WIDTH-1:TAG_LSB]);
  assign dcache_read_done = rd_hit;
  assign dcache_read_data = rd_hit ? a_data : '0;

  data_cache_array #(
    .LINE_NUM       (LINE_NUM),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .DATA_WIDTH     (DATA_WIDTH),
    .TAG_W          (TAG_W)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .a_idx       (dcache_read_addr[TAG_LSB-1:LINE_LSB]),
    .a_word      (dcache_read_addr[LINE_LSB-1:DC_OFF_W]),
    .a_valid     (a_valid),
    .a_tag       (a_tag),
    .a_data      (a_data),
    .b_idx       (b_idx),
    .b_valid     (b_valid),
    .b_tag       (b_tag),
    .we          (arr_we),
    .w_idx       (arr_idx),
    .w_word      (arr_word),
    .w_data      (arr_wdata),
    .w_mask      (arr_wmask),
    .w_set_valid (arr_set_valid),
    .w_tag       (arr_tag)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fill_line <= '0;
      fill_cnt  <= '0;
      pf_vld    <= 1'b0;
      pf_line   <= '0;
    end else begin
      state     <= state_nxt;
      fill_line <= fill_line_nxt;
      if (state == REFILL && mem_ack) begin
        fill_cnt <= fill_cnt + WORD_W'(1);
      end
      // A fresh hint always wins over clearing the slot in the same cycle.
      if (dcache_prefetch) begin
        pf_vld  <= 1'b1;
        pf_line <= dcache_pre_addr[ADDR_WIDTH-1:LINE_LSB];
      end else if (pf_clr) begin
        pf_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt         = state;
    fill_line_nxt     = fill_line;
    pf_clr            = 1'b0;
    mem_req           = 1'b0;
    mem_we            = 1'b0;
    mem_addr          = '0;
    mem_wdata         = '0;
    mem_wmask         = '0;
    dcache_write_done = 1'b0;
    arr_we            = 1'b0;
    arr_set_valid     = 1'b0;
    arr_idx           = '0;
    arr_word          = '0;
    arr_wdata         = '0;
    arr_wmask         = '0;
    arr_tag           = '0;
    case (state)
      IDLE: begin
        if (pf_vld && b_hit) begin
          pf_clr = 1'b1;
        end
        if (dcache_write) begin
          state_nxt = WRITE;
        end else if (dcache_read && !rd_hit) begin
          state_nxt     = REFILL;
          fill_line_nxt = dcache_read_addr[ADDR_WIDTH-1:LINE_LSB];
        end else if (pf_vld && !b_hit) begin
          state_nxt     = REFILL;
          fill_line_nxt = pf_line;
          pf_clr        = 1'b1;
        end
      end
      REFILL: begin
        mem_req   = 1'b1;
        mem_addr  = {fill_line, fill_cnt, {DC_OFF_W{1'b0}}};
        arr_idx   = fill_line[TAG_LSB-1:LINE_LSB];
        arr_word  = fill_cnt;
        arr_wdata = mem_rdata;
        arr_wmask = '1;
        arr_tag   = fill_line[ADDR_WIDTH-1:TAG_LSB];
        if (mem_ack) begin
          arr_we = 1'b1;
          if (fill_cnt == WORD_W'(WORDS_PER_LINE - 1)) begin
            arr_set_valid = 1'b1;
            state_nxt     = IDLE;
          end
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {dcache_write_addr[ADDR_WIDTH-1:DC_OFF_W], {DC_OFF_W{1'b0}}};
        mem_wdata = dcache_write_data;
        mem_wmask = dcache_write_mask;
        arr_idx   = dcache_write_addr[TAG_LSB-1:LINE_LSB];
        arr_word  = dcache_write_addr[LINE_LSB-1:DC_OFF_W];
        arr_wdata = dcache_write_data;
        arr_wmask = dcache_write_mask;
        if (mem_ack) begin
          dcache_write_done = 1'b1;
          arr_we            = b_hit;
          state_nxt         = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: memory responder plus a line-residency/backing-memory reference model.
`timescale 1ns/1ps
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dcache_read = 1'b0;
  logic [31:0] dcache_read_addr = '0;
  logic        dcache_read_done;
  logic [31:0] dcache_read_data;
  logic        dcache_prefetch = 1'b0;
  logic [31:0] dcache_pre_addr = '0;
  logic        dcache_write = 1'b0;
  logic [31:0] dcache_write_addr = '0;
  logic [31:0] dcache_write_data = '0;
  logic [3:0]  dcache_write_mask = '0;
  logic        dcache_write_done;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  data_cache dut (
    .clk(clk), .rst(rst),
    .dcache_read(dcache_read), .dcache_read_addr(dcache_read_addr),
    .dcache_read_done(dcache_read_done), .dcache_read_data(dcache_read_data),
    .dcache_prefetch(dcache_prefetch), .dcache_pre_addr(dcache_pre_addr),
    .dcache_write(dcache_write), .dcache_write_addr(dcache_write_addr),
    .dcache_write_data(dcache_write_data), .dcache_write_mask(dcache_write_mask),
    .dcache_write_done(dcache_write_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc_cnt = 0;
  int last_ack_cyc = 0;
  int wait_cnt = 0;
  bit rand_lat = 0;
  int rd_done_cyc = 0;
  logic rd_req = 1'b0;

  bit          log_we[$];
  logic [31:0] log_addr[$];
  logic [3:0]  log_mask[$];
  logic [31:0] mem_model [logic [31:0]];
  bit          res_vld [16];
  logic [31:0] res_line [16];

  always @(posedge clk) cyc_cnt++;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic void mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] w;
    w = mem_rd(a);
    for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = d[8*i +: 8];
    mem_model[a] = w;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 4) & 32'hF);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return res_vld[idx_of(a)] && (res_line[idx_of(a)] == (a & ~32'hF));
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    res_vld[idx_of(a)]  = 1'b1;
    res_line[idx_of(a)] = a & ~32'hF;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) res_vld[i] = 1'b0;
  endfunction

  function automatic bit fetched_ok(input int base, input logic [31:0] line);
    for (int k = 0; k < 4; k++) begin
      if (base + k >= log_addr.size()) return 1'b0;
      if (log_we[base+k] !== 1'b0 || log_addr[base+k] !== line + 32'(4*k)) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Memory responder: one-cycle ack pulses, gap of wait_cnt cycles between them.
  always @(negedge clk) begin
    if (!rst) begin
      mem_ack = 1'b0;
      wait_cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      wait_cnt = rand_lat ? int'($urandom_range(2, 0)) : 0;
    end else if (mem_req) begin
      if (wait_cnt == 0) begin
        mem_ack = 1'b1;
        log_we.push_back(mem_we);
        log_addr.push_back(mem_addr);
        log_mask.push_back(mem_wmask);
        last_ack_cyc = cyc_cnt;
        if (mem_we) mem_wr(mem_addr, mem_wdata, mem_wmask);
        else mem_rdata = mem_rd(mem_addr);
      end else begin
        wait_cnt--;
      end
    end
  end

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int lat, output bit ok);
    @(negedge clk);
    dcache_read = 1'b1;
    dcache_read_addr = a;
    ok = 1'b0; lat = 0; d = '0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (dcache_read_done) begin
        d = dcache_read_data; ok = 1'b1; rd_done_cyc = cyc_cnt; rd_req = mem_req;
        break;
      end
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
    dcache_read = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, output bit ok);
    @(negedge clk);
    dcache_write = 1'b1;
    dcache_write_addr = a; dcache_write_data = d; dcache_write_mask = m;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (dcache_write_done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    dcache_write = 1'b0;
  endtask

  task automatic pulse_prefetch(input logic [31:0] a);
    @(negedge clk);
    dcache_prefetch = 1'b1;
    dcache_pre_addr = a;
    @(negedge clk);
    dcache_prefetch = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({mem_req, mem_we, dcache_read_done, dcache_write_done} !== 4'b0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || mem_wmask !== 4'h0 || dcache_read_data !== 32'h0)
      $display("FAIL reset_outputs req=%b we=%b rdone=%b wdone=%b addr=%h wdata=%h wmask=%b rdata=%h, required all zero",
               mem_req, mem_we, dcache_read_done, dcache_write_done, mem_addr, mem_wdata, mem_wmask, dcache_read_data);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_read_miss;
    logic [31:0] d; int lat; bit ok; int base;
    mem_model[32'h100] = 32'hA0A0_A0A0; mem_model[32'h104] = 32'hA1A1_A1A1;
    mem_model[32'h108] = 32'hA2A2_A2A2; mem_model[32'h10C] = 32'hA3A3_A3A3;
    base = log_addr.size();
    do_read(32'h100, d, lat, ok);
    n_checks++;
    if (!ok || d !== 32'hA0A0_A0A0) $display("FAIL miss_data ok=%b data=%h required %h", ok, d, 32'hA0A0_A0A0);
    else n_pass++;
    n_checks++;
    if (!fetched_ok(base, 32'h100) || log_addr.size() !== base + 4)
      $display("FAIL miss_fetch_seq mem ops=%0d required 4 reads 0x100..0x10C", log_addr.size() - base);
    else n_pass++;
    n_checks++;
    if (rd_done_cyc !== last_ack_cyc + 1)
      $display("FAIL miss_done_timing done_cycle=%0d required %0d", rd_done_cyc, last_ack_cyc + 1);
    else n_pass++;
    model_fill(32'h100);
  endtask

  task automatic test_read_hit;
    logic [31:0] d; int lat; bit ok; int base;
    base = log_addr.size();
    do_read(32'h108, d, lat, ok);
    n_checks++;
    if (!ok || lat !== 0 || rd_req !== 1'b0 || log_addr.size() !== base)
      $display("FAIL hit_latency ok=%b lat=%0d mem_req=%b mem_ops=%0d required lat 0, no mem ops", ok, lat, rd_req, log_addr.size() - base);
    else n_pass++;
    n_checks++;
    if (d !== 32'hA2A2_A2A2) $display("FAIL hit_data data=%h required %h", d, 32'hA2A2_A2A2);
    else n_pass++;
  endtask

  task automatic test_store;
    logic [31:0] d; int lat; bit ok; int base;
    base = log_addr.size();
    do_write(32'h104, 32'h0000_BEEF, 4'b0011, ok);
    n_checks++;
    if (!ok || log_addr.size() !== base + 1 || log_we[base] !== 1'b1 || log_addr[base] !== 32'h104 || log_mask[base] !== 4'b0011)
      $display("FAIL store_hit_mem ok=%b ops=%0d addr=%h mask=%b required 1 write 0x104 mask 0011",
               ok, log_addr.size() - base, log_addr[base], log_mask[base]);
    else n_pass++;
    do_read(32'h104, d, lat, ok);
    n_checks++;
    if (!ok || lat !== 0 || d !== 32'hA1A1_BEEF) $display("FAIL store_merge lat=%0d data=%h required lat 0 data a1a1beef", lat, d);
    else n_pass++;
    base = log_addr.size();
    do_write(32'h900, 32'h1234_5678, 4'b1111, ok);
    repeat (5) @(negedge clk);
    n_checks++;
    if (!ok || log_addr.size() !== base + 1 || log_we[base] !== 1'b1 || log_addr[base] !== 32'h900)
      $display("FAIL store_miss_noalloc ok=%b ops=%0d addr=%h required single write 0x900", ok, log_addr.size() - base, log_addr[base]);
    else n_pass++;
    do_read(32'h100, d, lat, ok);
    n_checks++;
    if (!ok || lat !== 0 || d !== 32'hA0A0_A0A0) $display("FAIL store_miss_keeps_line lat=%0d data=%h required lat 0 data a0a0a0a0", lat, d);
    else n_pass++;
  endtask

  task automatic test_prefetch;
    logic [31:0] d; int lat; bit ok; int base; bit done;
    base = log_addr.size();
    pulse_prefetch(32'h200);
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (log_addr.size() >= base + 4 && !mem_req) begin done = 1'b1; break; end
    end
    n_checks++;
    if (!done || !fetched_ok(base, 32'h200) || log_addr.size() !== base + 4)
      $display("FAIL prefetch_fill done=%b ops=%0d required 4 reads 0x200..0x20C", done, log_addr.size() - base);
    else n_pass++;
    model_fill(32'h200);
    do_read(32'h204, d, lat, ok);
    n_checks++;
    if (!ok || lat !== 0 || d !== mem_rd(32'h204)) $display("FAIL prefetch_hit lat=%0d data=%h required lat 0 data %h", lat, d, mem_rd(32'h204));
    else n_pass++;
  endtask

  task automatic test_prefetch_overwrite;
    logic [31:0] d; int lat; bit ok; int base; bit busy; bit done;
    base = log_addr.size();
    busy = 1'b0;
    fork
      do_read(32'h600, d, lat, ok);
      begin
        for (int i = 0; i < 50; i++) begin
          @(negedge clk); #1;
          if (mem_req) begin busy = 1'b1; break; end
        end
        @(negedge clk); dcache_prefetch = 1'b1; dcache_pre_addr = 32'h300;
        @(negedge clk); dcache_pre_addr = 32'h400;
        @(negedge clk); dcache_prefetch = 1'b0;
      end
    join
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (log_addr.size() >= base + 8 && !mem_req) begin done = 1'b1; break; end
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (!ok || d !== mem_rd(32'h600)) $display("FAIL busy_read_data ok=%b data=%h required %h", ok, d, mem_rd(32'h600));
    else n_pass++;
    n_checks++;
    if (!busy || !done || !fetched_ok(base, 32'h600) || !fetched_ok(base + 4, 32'h400) || log_addr.size() !== base + 8)
      $display("FAIL prefetch_newest_wins busy=%b done=%b ops=%0d required 0x600 line then 0x400 line only",
               busy, done, log_addr.size() - base);
    else n_pass++;
    model_fill(32'h600);
    model_fill(32'h400);
  endtask

  task automatic test_write_vs_read;
    logic [31:0] d; int lat; bit rok; bit wok; int base;
    base = log_addr.size();
    fork
      do_write(32'h700, 32'hCAFE_F00D, 4'b1111, wok);
      do_read(32'h800, d, lat, rok);
    join
    n_checks++;
    if (!wok || !rok || log_addr.size() !== base + 5 || log_we[base] !== 1'b1 || log_addr[base] !== 32'h700 || !fetched_ok(base + 1, 32'h800))
      $display("FAIL write_before_refill wok=%b rok=%b ops=%0d first_we=%b first_addr=%h required write 0x700 then 4 reads 0x800",
               wok, rok, log_addr.size() - base, log_we[base], log_addr[base]);
    else n_pass++;
    n_checks++;
    if (d !== mem_rd(32'h800)) $display("FAIL write_vs_read_data data=%h required %h", d, mem_rd(32'h800));
    else n_pass++;
    model_fill(32'h800);
  endtask

  task automatic test_reset_mid_refill;
    logic [31:0] d; int lat; bit ok; int base; bit found;
    base = log_addr.size();
    @(negedge clk);
    dcache_read = 1'b1;
    dcache_read_addr = 32'h500;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (log_addr.size() == base + 2 && !mem_ack && mem_req) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found || mem_addr !== 32'h508) $display("FAIL third_word_req found=%b addr=%h required 00000508", found, mem_addr);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || dcache_read_done !== 1'b0 || dcache_write_done !== 1'b0 || mem_addr !== 32'h0)
      $display("FAIL reset_abort req=%b rdone=%b wdone=%b addr=%h required all zero", mem_req, dcache_read_done, dcache_write_done, mem_addr);
    else n_pass++;
    dcache_read = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_clear();
    base = log_addr.size();
    do_read(32'h500, d, lat, ok);
    n_checks++;
    if (!ok || lat == 0 || !fetched_ok(base, 32'h500) || log_addr.size() !== base + 4)
      $display("FAIL refetch_after_reset ok=%b lat=%0d ops=%0d required full 4-word refill", ok, lat, log_addr.size() - base);
    else n_pass++;
    n_checks++;
    if (d !== mem_rd(32'h500)) $display("FAIL refetch_data data=%h required %h", d, mem_rd(32'h500));
    else n_pass++;
    model_fill(32'h500);
  endtask

  task automatic test_random;
    logic [31:0] a, d, wd; logic [3:0] m; int lat; bit ok; int base; bit hit;
    rand_lat = 1'b1;
    for (int n = 0; n < 60; n++) begin
      a = 32'($urandom_range(255, 0)) << 2;
      base = log_addr.size();
      if ($urandom_range(1, 0) == 1) begin
        hit = model_hit(a);
        do_read(a, d, lat, ok);
        n_checks++;
        if (hit ? (!ok || lat !== 0 || log_addr.size() !== base)
                : (!ok || !fetched_ok(base, a & ~32'hF) || log_addr.size() !== base + 4 || rd_done_cyc !== last_ack_cyc + 1))
          $display("FAIL rand_read_traffic addr=%h hit_expected=%b ok=%b lat=%0d ops=%0d", a, hit, ok, lat, log_addr.size() - base);
        else n_pass++;
        n_checks++;
        if (d !== mem_rd(a)) $display("FAIL rand_read_data addr=%h data=%h required %h", a, d, mem_rd(a));
        else n_pass++;
        model_fill(a);
      end else begin
        wd = $urandom;
        m = 4'($urandom_range(15, 0));
        do_write(a, wd, m, ok);
        n_checks++;
        if (!ok || log_addr.size() !== base + 1 || log_we[base] !== 1'b1 || log_addr[base] !== a || log_mask[base] !== m)
          $display("FAIL rand_write addr=%h ok=%b ops=%0d got_addr=%h got_mask=%b required one write mask %b",
                   a, ok, log_addr.size() - base, log_addr[base], log_mask[base], m);
        else n_pass++;
      end
    end
    rand_lat = 1'b0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_read_miss();
    test_read_hit();
    test_store();
    test_prefetch();
    test_prefetch_overwrite();
    test_write_vs_read();
    test_reset_mid_refill();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached, checks so far %0d/%0d", n_pass, n_checks);
    $fatal(1, "time limit");
  end

endmodule
